// File: rtl/keypad_scanner_4x4_if.sv
// Pin-side and consumer-side signals of the 4x4 keypad scanner, bundled for port connection.
// master = scanner, slave = board/operand-capture side.
interface keypad_scanner_4x4_if;
    logic [3:0] fil;
    logic [3:0] col;
    logic [3:0] tecla_hex;
    logic       tecla_valida;
    logic       tecla_presionada;

    modport master (
        input  fil,
        output col,
        output tecla_hex,
        output tecla_valida,
        output tecla_presionada
    );

    modport slave (
        output fil,
        input  col,
        input  tecla_hex,
        input  tecla_valida,
        input  tecla_presionada
    );
endinterface

// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: column drive, single-key debounce, hex encoding, one-clock valid pulse.
// Optional auto-repeat of a held key is compiled in with `define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner_4x4 #(
    parameter int SCAN_DIV     = 27000,
    parameter int DEBOUNCE_N   = 4,
    parameter int REPEAT_TICKS = 500
) (
    input logic clk,
    input logic rst,
    keypad_scanner_4x4_if.master bus
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_N + 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_divCnt;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_col;
    logic [3:0]       r_row;
    logic [3:0]       r_hex;
    logic             r_valid;

    state_t           w_stateNext;
    logic [CNT_W-1:0] w_cntNext;
    logic [CNT_W-1:0] w_cntInc;
    logic [3:0]       w_colNext;
    logic [3:0]       w_colRot;
    logic [3:0]       w_rowNext;
    logic [3:0]       w_hexNext;
    logic             w_validNext;
    logic             w_tick;
    logic             w_filIdle;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);
    logic [REP_W-1:0] r_rep;
    logic [REP_W-1:0] w_repNext;
    logic [REP_W-1:0] w_repInc;
`else
    logic w_unusedRepeatCfg;
    assign w_unusedRepeatCfg = (REPEAT_TICKS > 0);
`endif

    function automatic logic singleLow(input logic [3:0] v);
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: singleLow = 1'b1;
            default:                            singleLow = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] lowIdx(input logic [3:0] v);
        case (v)
            4'b1110: lowIdx = 2'd0;
            4'b1101: lowIdx = 2'd1;
            4'b1011: lowIdx = 2'd2;
            default: lowIdx = 2'd3;
        endcase
    endfunction

    // Row/column to keycap legend; '*' encodes as E and '#' as F.
    function automatic logic [3:0] keyMap(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: keyMap = 4'h1;
            4'b00_01: keyMap = 4'h2;
            4'b00_10: keyMap = 4'h3;
            4'b00_11: keyMap = 4'hA;
            4'b01_00: keyMap = 4'h4;
            4'b01_01: keyMap = 4'h5;
            4'b01_10: keyMap = 4'h6;
            4'b01_11: keyMap = 4'hB;
            4'b10_00: keyMap = 4'h7;
            4'b10_01: keyMap = 4'h8;
            4'b10_10: keyMap = 4'h9;
            4'b10_11: keyMap = 4'hC;
            4'b11_00: keyMap = 4'hE;
            4'b11_01: keyMap = 4'h0;
            4'b11_10: keyMap = 4'hF;
            default:  keyMap = 4'hD;
        endcase
    endfunction

    assign w_tick    = (r_divCnt == DIV_W'(SCAN_DIV - 1));
    assign w_filIdle = (bus.fil == 4'hF);
    assign w_colRot  = {r_col[2:0], r_col[3]};
    assign w_cntInc  = (r_cnt < CNT_W'(DEBOUNCE_N)) ? r_cnt + CNT_W'(1) : r_cnt;
`ifdef KEYPAD_AUTOREPEAT_EN
    assign w_repInc  = (r_rep < REP_W'(REPEAT_TICKS)) ? r_rep + REP_W'(1) : r_rep;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_SCAN;
            r_divCnt <= '0;
            r_cnt    <= '0;
            r_col    <= 4'b1110;
            r_row    <= 4'hF;
            r_hex    <= 4'h0;
            r_valid  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep    <= '0;
`endif
        end else begin
            r_state  <= w_stateNext;
            r_divCnt <= w_tick ? '0 : r_divCnt + DIV_W'(1);
            r_cnt    <= w_cntNext;
            r_col    <= w_colNext;
            r_row    <= w_rowNext;
            r_hex    <= w_hexNext;
            r_valid  <= w_validNext;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep    <= w_repNext;
`endif
        end
    end

    // The column only advances when the FSM is back in SCAN, so a held key keeps its column driven.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_colNext   = r_col;
        w_rowNext   = r_row;
        w_hexNext   = r_hex;
        w_validNext = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        w_repNext   = r_rep;
`endif
        if (w_tick) begin
            case (r_state)
                ST_SCAN: begin
                    if (singleLow(bus.fil)) begin
                        w_rowNext = bus.fil;
                        if (DEBOUNCE_N == 1) begin
                            w_stateNext = ST_PRESSED;
                            w_cntNext   = '0;
                            w_hexNext   = keyMap(lowIdx(bus.fil), lowIdx(r_col));
                            w_validNext = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            w_repNext   = '0;
`endif
                        end else begin
                            w_stateNext = ST_DEBOUNCE;
                            w_cntNext   = CNT_W'(1);
                        end
                    end else begin
                        w_colNext = w_colRot;
                    end
                end
                ST_DEBOUNCE: begin
                    if (bus.fil == r_row) begin
                        if (w_cntInc == CNT_W'(DEBOUNCE_N)) begin
                            w_stateNext = ST_PRESSED;
                            w_cntNext   = '0;
                            w_hexNext   = keyMap(lowIdx(r_row), lowIdx(r_col));
                            w_validNext = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            w_repNext   = '0;
`endif
                        end else begin
                            w_cntNext = w_cntInc;
                        end
                    end else begin
                        w_stateNext = ST_SCAN;
                        w_cntNext   = '0;
                        w_colNext   = w_colRot;
                    end
                end
                ST_PRESSED: begin
                    if (w_filIdle) begin
                        if (DEBOUNCE_N == 1) begin
                            w_stateNext = ST_SCAN;
                            w_cntNext   = '0;
                            w_colNext   = w_colRot;
                        end else begin
                            w_stateNext = ST_RELEASE;
                            w_cntNext   = CNT_W'(1);
                        end
                    end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (w_repInc == REP_W'(REPEAT_TICKS)) begin
                            w_validNext = 1'b1;
                            w_repNext   = '0;
                        end else begin
                            w_repNext   = w_repInc;
                        end
`endif
                    end
                end
                ST_RELEASE: begin
                    if (w_filIdle) begin
                        if (w_cntInc == CNT_W'(DEBOUNCE_N)) begin
                            w_stateNext = ST_SCAN;
                            w_cntNext   = '0;
                            w_colNext   = w_colRot;
                        end else begin
                            w_cntNext = w_cntInc;
                        end
                    end else begin
                        // Release bounce: back to the held state without a new pulse.
                        w_stateNext = ST_PRESSED;
                        w_cntNext   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        w_repNext   = '0;
`endif
                    end
                end
                default: begin
                    w_stateNext = ST_SCAN;
                    w_cntNext   = '0;
                end
            endcase
        end
    end

    assign bus.col              = r_col;
    assign bus.tecla_hex        = r_hex;
    assign bus.tecla_valida     = r_valid;
    assign bus.tecla_presionada = (r_state == ST_PRESSED) || (r_state == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Self-checking bench for keypad_scanner_4x4: a key matrix model drives fil from col, a pulse
// monitor collects every tecla_valida, and directed, table and random sequences check the results.
module tb_keypad_scanner_4x4;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_N   = 3;
    localparam int REPEAT_TICKS = 5;

    typedef struct {
        int         row;
        int         colIdx;
        logic [3:0] expHex;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [15:0] keyMask = '0;
    int checks = 0;
    int errors = 0;
    int nEdges = 0;
    logic [3:0] pulseQ[$];
    logic [3:0] prevHex = 4'h0;
    logic prevValid = 1'b0;
    logic [3:0] modelMap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                  4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    keypad_scanner_4x4_if bus ();

    keypad_scanner_4x4 #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_N  (DEBOUNCE_N),
        .REPEAT_TICKS(REPEAT_TICKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // A pressed key at (r,c) pulls row r low whenever column c is driven low.
    always_comb begin
        bus.fil = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keyMask[r*4+c] && !bus.col[c]) bus.fil[r] = 1'b0;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int key, input bit down);
        keyMask[key] = down;
    endtask

    task automatic stepClk();
        @(negedge clk);
        nEdges++;
    endtask

    task automatic stepTo(input int n);
        while (nEdges < n) stepClk();
    endtask

    task automatic waitTicks(input int n);
        repeat (n) begin
            do stepClk(); while (nEdges % SCAN_DIV != 0);
        end
    endtask

    task automatic waitPulse(input int maxTicks, input string name);
        int t = 0;
        while (pulseQ.size() == 0 && t < maxTicks) begin
            waitTicks(1);
            t++;
        end
        checkOutput({name, "_pulseSeen"}, 32'(pulseQ.size() > 0), 32'd1);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nEdges = 0;
        pulseQ.delete();
    endtask

    function automatic logic [3:0] colFor(input int idx);
        logic [3:0] v;
        v = 4'b0001 << idx;
        return ~v;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst) begin
            prevHex   = 4'h0;
            prevValid = 1'b0;
        end else begin
            if (bus.tecla_valida) begin
                pulseQ.push_back(bus.tecla_hex);
                checkOutput("validOneClk", 32'(prevValid), 32'd0);
            end
            if (bus.tecla_hex !== prevHex)
                checkOutput("hexChangesOnlyOnPulse", 32'(bus.tecla_valida), 32'd1);
            prevHex   = bus.tecla_hex;
            prevValid = bus.tecla_valida;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[16];
        logic [3:0] prevCol;
        int k;
        int hold;
        int expPulses;
        bit found;

        vecs = '{'{0,0,4'h1}, '{0,1,4'h2}, '{0,2,4'h3}, '{0,3,4'hA},
                 '{1,0,4'h4}, '{1,1,4'h5}, '{1,2,4'h6}, '{1,3,4'hB},
                 '{2,0,4'h7}, '{2,1,4'h8}, '{2,2,4'h9}, '{2,3,4'hC},
                 '{3,0,4'hE}, '{3,1,4'h0}, '{3,2,4'hF}, '{3,3,4'hD}};

        // Reset values appear before any clock edge.
        #2 rst = 1'b1;
        #1;
        checkOutput("rstCol", bus.col, 4'b1110);
        checkOutput("rstHex", bus.tecla_hex, 4'h0);
        checkOutput("rstValid", bus.tecla_valida, 1'b0);
        checkOutput("rstPressed", bus.tecla_presionada, 1'b0);

        // Key '6' exact timing: detect at tick 3 (col 1011), accept at tick 5.
        doReset();
        applyStimulus(6, 1'b1);
        stepTo(19);
        checkOutput("k6NoEarlyValid", bus.tecla_valida, 1'b0);
        stepTo(20);
        checkOutput("k6Valid", bus.tecla_valida, 1'b1);
        checkOutput("k6Hex", bus.tecla_hex, 4'h6);
        checkOutput("k6Pressed", bus.tecla_presionada, 1'b1);
        stepTo(21);
        checkOutput("k6ValidDrop", bus.tecla_valida, 1'b0);
        applyStimulus(6, 1'b0);
        stepTo(31);
        checkOutput("k6StillHeld", bus.tecla_presionada, 1'b1);
        stepTo(32);
        checkOutput("k6Released", bus.tecla_presionada, 1'b0);
        checkOutput("k6ColResume", bus.col, 4'b0111);
        stepTo(36);
        checkOutput("k6ColNext", bus.col, 4'b1110);
        checkOutput("k6PulseCount", pulseQ.size(), 1);

        // Mid-operation asynchronous reset while '6' is held and accepted.
        pulseQ.delete();
        applyStimulus(6, 1'b1);
        waitPulse(8, "midRstSetup");
        stepClk();
        stepClk();
        #2 rst = 1'b1;
        #1;
        checkOutput("midRstCol", bus.col, 4'b1110);
        checkOutput("midRstHex", bus.tecla_hex, 4'h0);
        checkOutput("midRstValid", bus.tecla_valida, 1'b0);
        checkOutput("midRstPressed", bus.tecla_presionada, 1'b0);
        applyStimulus(6, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        nEdges = 0;
        pulseQ.delete();
        for (int e = 1; e <= 16; e++) begin
            stepClk();
            checkOutput("idleColCycle", bus.col, colFor((e / SCAN_DIV) % 4));
        end

        // Every key of the map, one press each.
        for (int i = 0; i < 16; i++) begin
            pulseQ.delete();
            applyStimulus(vecs[i].row * 4 + vecs[i].colIdx, 1'b1);
            waitPulse(8, "table");
            if (pulseQ.size() > 0) checkOutput("tablePulseHex", pulseQ[0], vecs[i].expHex);
            checkOutput("tableHexOut", bus.tecla_hex, vecs[i].expHex);
            applyStimulus(vecs[i].row * 4 + vecs[i].colIdx, 1'b0);
            waitTicks(5);
            checkOutput("tablePulseCount", pulseQ.size(), 1);
        end

        // Bouncing press on 'D': one tick low, one tick high, then stable.
        pulseQ.delete();
        found = 1'b0;
        for (int t = 0; t < 8 && !found; t++) begin
            waitTicks(1);
            if (bus.col == 4'b0111) found = 1'b1;
        end
        checkOutput("bounceAlign", 32'(found), 32'd1);
        applyStimulus(15, 1'b1);
        waitTicks(1);
        applyStimulus(15, 1'b0);
        waitTicks(1);
        checkOutput("bounceNoPulse", pulseQ.size(), 0);
        checkOutput("bounceColRotated", bus.col, 4'b1110);
        checkOutput("bounceNotPressed", bus.tecla_presionada, 1'b0);
        applyStimulus(15, 1'b1);
        waitPulse(12, "bounceStable");
        checkOutput("bounceHex", bus.tecla_hex, 4'hD);
        applyStimulus(15, 1'b0);
        waitTicks(5);
        checkOutput("bouncePulseCount", pulseQ.size(), 1);

        // Release bounce on '0'.
        pulseQ.delete();
        applyStimulus(13, 1'b1);
        waitPulse(8, "relBounce");
        waitTicks(1);
        applyStimulus(13, 1'b0);
        waitTicks(1);
        checkOutput("relBounceHeld1", bus.tecla_presionada, 1'b1);
        applyStimulus(13, 1'b1);
        waitTicks(1);
        checkOutput("relBounceHeld2", bus.tecla_presionada, 1'b1);
        applyStimulus(13, 1'b0);
        waitTicks(2);
        checkOutput("relBounceHeld3", bus.tecla_presionada, 1'b1);
        waitTicks(1);
        checkOutput("relBounceDone", bus.tecla_presionada, 1'b0);
        checkOutput("relBouncePulses", pulseQ.size(), 1);
        checkOutput("relBounceHex", bus.tecla_hex, 4'h0);

        // Two rows low in column 0 ('1' and '4'): ignored, scanning continues.
        pulseQ.delete();
        applyStimulus(0, 1'b1);
        applyStimulus(4, 1'b1);
        waitTicks(1);
        prevCol = bus.col;
        for (int t = 0; t < 8; t++) begin
            waitTicks(1);
            checkOutput("twoRowsRotate", bus.col, {prevCol[2:0], prevCol[3]});
            prevCol = bus.col;
        end
        checkOutput("twoRowsNoPulse", pulseQ.size(), 0);
        checkOutput("twoRowsNotPressed", bus.tecla_presionada, 1'b0);
        applyStimulus(0, 1'b0);
        applyStimulus(4, 1'b0);
        waitTicks(2);

        // Hold 'A' for 12 ticks after acceptance.
        pulseQ.delete();
        applyStimulus(3, 1'b1);
        waitPulse(8, "repeatA");
        waitTicks(12);
        applyStimulus(3, 1'b0);
        waitTicks(5);
`ifdef KEYPAD_AUTOREPEAT_EN
        expPulses = 3;
`else
        expPulses = 1;
`endif
        checkOutput("repeatCount", pulseQ.size(), expPulses);
        foreach (pulseQ[i]) checkOutput("repeatHex", pulseQ[i], 4'hA);

        // Random single-key presses against the key-map model.
        for (int n = 0; n < 20; n++) begin
            pulseQ.delete();
            k = $urandom_range(0, 15);
            hold = $urandom_range(10, 16);
            applyStimulus(k, 1'b1);
            waitTicks(hold);
            checkOutput("randHeld", bus.tecla_presionada, 1'b1);
            checkOutput("randHexOut", bus.tecla_hex, modelMap[k]);
            applyStimulus(k, 1'b0);
            waitTicks(5);
            checkOutput("randReleased", bus.tecla_presionada, 1'b0);
`ifdef KEYPAD_AUTOREPEAT_EN
            checkOutput("randPulseRange",
                        32'(pulseQ.size() >= 1 && pulseQ.size() <= 1 + hold / REPEAT_TICKS), 32'd1);
`else
            checkOutput("randPulseCount", pulseQ.size(), 1);
`endif
            foreach (pulseQ[i]) checkOutput("randPulseHex", pulseQ[i], modelMap[k]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
